// File: rtl/conv3d_window_sched.sv
// conv3d_window_sched: address/flag sequencer for one 3D convolution pass.
// Walks a KSZ x KSZ x CH window over a CH x IMG_H x IMG_W map with a latched
// runtime stride, issuing one input-buffer and one weight-buffer address per
// beat, framed with first/last flags and throttled by mac_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stride     pass request (sampled in IDLE) and window step (0 -> 1)
//   mac_ready         MAC accepts the current beat
//   mac_valid/first/last, in_addr, w_addr   beat to the MAC
//   out_row, out_col  top-left corner of the current window
//   busy, done        pass in progress / one-cycle completion pulse
module conv3d_window_sched #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned KSZ    = 3,
  parameter int unsigned CH     = 3,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        stride,
  input  logic              mac_ready,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
  output logic [ADDR_W-1:0] in_addr,
  output logic [WA_W-1:0]   w_addr,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              busy,
  output logic              done
);

  localparam int unsigned KX_W   = (KSZ > 1) ? $clog2(KSZ) : 1;
  localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned POS_W  = 6;
  localparam int unsigned SUM_W  = $clog2(CH * IMG_H * IMG_W + 1) + 1;
  localparam int unsigned WSUM_W = $clog2(CH * KSZ * KSZ + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state_q;
  logic [KX_W-1:0]   kx_q, kx_d, ky_q, ky_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [3:0]        col_q, col_d, row_q, row_d;
  logic [1:0]        stride_q;

  logic              kx_last_c, ky_last_c, ch_last_c, col_fits_c, row_fits_c;
  logic              pass_end_c, first_c, last_c;
  logic [SUM_W-1:0]  in_sum_c;
  logic [WSUM_W-1:0] w_sum_c;

  // Position of the current beat within its window and of the next window.
  always_comb begin
    kx_last_c  = (kx_q == KX_W'(KSZ - 1));
    ky_last_c  = (ky_q == KX_W'(KSZ - 1));
    ch_last_c  = (ch_q == CH_W'(CH - 1));
    col_fits_c = (POS_W'(col_q) + POS_W'(stride_q) + POS_W'(KSZ)) <= POS_W'(IMG_W);
    row_fits_c = (POS_W'(row_q) + POS_W'(stride_q) + POS_W'(KSZ)) <= POS_W'(IMG_H);
    pass_end_c = kx_last_c && ky_last_c && ch_last_c && !col_fits_c && !row_fits_c;
  end

  // Next counters: cleared in IDLE, advanced by one beat in RUN (committed only on accept).
  always_comb begin
    kx_d  = kx_q;
    ky_d  = ky_q;
    ch_d  = ch_q;
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE) begin
      kx_d  = '0;
      ky_d  = '0;
      ch_d  = '0;
      col_d = '0;
      row_d = '0;
    end else if (state_q == RUN) begin
      if (!kx_last_c) begin
        kx_d = kx_q + KX_W'(1);
      end else begin
        kx_d = '0;
        if (!ky_last_c) begin
          ky_d = ky_q + KX_W'(1);
        end else begin
          ky_d = '0;
          if (!ch_last_c) begin
            ch_d = ch_q + CH_W'(1);
          end else begin
            ch_d = '0;
            if (col_fits_c) begin
              col_d = col_q + 4'(stride_q);
            end else begin
              col_d = '0;
              row_d = row_q + 4'(stride_q);
            end
          end
        end
      end
    end
  end

  // Addresses and flags for the beat the counters are about to hold.
  always_comb begin
    in_sum_c = SUM_W'(ch_d) * SUM_W'(IMG_H * IMG_W)
             + (SUM_W'(row_d) + SUM_W'(ky_d)) * SUM_W'(IMG_W)
             + SUM_W'(col_d) + SUM_W'(kx_d);
    w_sum_c  = WSUM_W'(ch_d) * WSUM_W'(KSZ * KSZ)
             + WSUM_W'(ky_d) * WSUM_W'(KSZ) + WSUM_W'(kx_d);
    first_c  = (kx_d == '0) && (ky_d == '0) && (ch_d == '0);
    last_c   = (kx_d == KX_W'(KSZ - 1)) && (ky_d == KX_W'(KSZ - 1)) && (ch_d == CH_W'(CH - 1));
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      kx_q      <= '0;
      ky_q      <= '0;
      ch_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      stride_q  <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            stride_q <= (stride == 2'd0) ? 2'd1 : stride;
            kx_q     <= kx_d;
            ky_q     <= ky_d;
            ch_q     <= ch_d;
            col_q    <= col_d;
            row_q    <= row_d;
            mac_valid <= 1'b1;
            mac_first <= first_c;
            mac_last  <= last_c;
            in_addr   <= ADDR_W'(in_sum_c);
            w_addr    <= WA_W'(w_sum_c);
            out_row   <= row_d;
            out_col   <= col_d;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (mac_ready) begin
            if (pass_end_c) begin
              state_q   <= FIN;
              mac_valid <= 1'b0;
              mac_first <= 1'b0;
              mac_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              kx_q      <= kx_d;
              ky_q      <= ky_d;
              ch_q      <= ch_d;
              col_q     <= col_d;
              row_q     <= row_d;
              mac_first <= first_c;
              mac_last  <= last_c;
              in_addr   <= ADDR_W'(in_sum_c);
              w_addr    <= WA_W'(w_sum_c);
              out_row   <= row_d;
              out_col   <= col_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3d_window_sched.sv
// Testbench for conv3d_window_sched: table of passes checked beat-by-beat
// against a nested-loop reference trace, with random backpressure.
module tb_conv3d_window_sched;

  localparam int IMG_W = 8, IMG_H = 8, KSZ = 3, CH = 3;

  logic       clk = 1'b0;
  logic       rst, start, mac_ready;
  logic [1:0] stride;
  logic       mac_valid, mac_first, mac_last, busy, done;
  logic [8:0] in_addr;
  logic [4:0] w_addr;
  logic [3:0] out_row, out_col;

  int checks = 0;
  int errors = 0;

  conv3d_window_sched dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .mac_ready(mac_ready),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
    .in_addr(in_addr), .w_addr(w_addr), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [26:0] obs = {mac_valid, mac_first, mac_last, in_addr, w_addr, out_row, out_col, busy, done};
  wire [23:0] beat_obs = {in_addr, w_addr, mac_first, mac_last, out_row, out_col};

  typedef struct {
    logic [1:0] s;
    int         pct;
    bit         glitch;
    int         abort_at;
    int         beats;
    int         last_in;
    int         last_w;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One pass: builds the expected beat trace from the window rules, then
  // drives start/mac_ready and compares every accepted beat.
  task automatic run_pass(input vec_t v, output int beats, output int last_in, output int last_w);
    logic [23:0] q[$];
    logic [26:0] prev;
    bit          prev_stall = 1'b0;
    bit          expect_done = 1'b0;
    int          se = (v.s == 2'd0) ? 1 : int'(v.s);
    int          cyc = 0;
    beats = 0; last_in = -1; last_w = -1;
    for (int r = 0; r + KSZ <= IMG_H; r += se)
      for (int c = 0; c + KSZ <= IMG_W; c += se)
        for (int ch = 0; ch < CH; ch++)
          for (int ky = 0; ky < KSZ; ky++)
            for (int kx = 0; kx < KSZ; kx++)
              q.push_back({9'(ch * IMG_H * IMG_W + (r + ky) * IMG_W + c + kx),
                           5'(ch * KSZ * KSZ + ky * KSZ + kx),
                           (kx == 0 && ky == 0 && ch == 0),
                           (kx == KSZ - 1 && ky == KSZ - 1 && ch == CH - 1),
                           4'(r), 4'(c)});
    @(negedge clk);
    stride = v.s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; stride = 2'($urandom);
    while (1) begin
      cyc++;
      start = 1'b0;
      if (cyc > 6000) begin
        chk("timeout", 32'(cyc), 32'd0);
        break;
      end
      if (expect_done) begin
        chk("fin_cycle", {29'd0, done, busy, mac_valid}, 32'b100);
        if (v.glitch) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_fin", {29'd0, done, busy, mac_valid}, 32'd0);
        @(negedge clk);
        chk("no_requeue", {31'd0, mac_valid}, 32'd0);
        break;
      end
      chk("run_state", {29'd0, mac_valid, busy, done}, 32'b110);
      if (prev_stall) chk("stall_hold", 32'(obs), 32'(prev));
      if (v.abort_at > 0 && beats == v.abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_zero", 32'(obs), 32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        break;
      end
      mac_ready = ($urandom_range(0, 99) < 32'(v.pct));
      if (mac_ready) begin
        chk("beat", 32'(beat_obs), 32'(q.pop_front()));
        beats++;
        last_in = int'(in_addr);
        last_w  = int'(w_addr);
        if (q.size() == 0) expect_done = 1'b1;
      end
      prev = obs;
      prev_stall = !mac_ready;
      if (v.glitch && beats == 50 && mac_ready) start = 1'b1;
      @(negedge clk);
    end
    mac_ready = 1'b0;
    start = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    int b, li, lw;
    tbl[0] = '{2'd1, 100, 1'b0, 0,   972, 191, 26};
    tbl[1] = '{2'd2, 100, 1'b0, 0,   243, 182, 26};
    tbl[2] = '{2'd0, 100, 1'b0, 0,   972, 191, 26};
    tbl[3] = '{2'd3, 100, 1'b0, 0,   108, 173, 26};
    tbl[4] = '{2'd1, 50,  1'b0, 0,   972, 191, 26};
    tbl[5] = '{2'd1, 100, 1'b0, 100, 100, -1,  -1};
    tbl[6] = '{2'd1, 60,  1'b0, 0,   972, 191, 26};
    tbl[7] = '{2'd2, 100, 1'b1, 0,   243, 182, 26};

    rst = 1'b1; start = 1'b0; stride = 2'd0; mac_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(obs), 32'd0);
    rst = 1'b0;

    // start and rst together: reset wins, no pass begins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; stride = 2'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_wins", 32'(obs), 32'd0);
    @(negedge clk);
    chk("rst_wins_idle", {31'd0, mac_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_pass(tbl[i], b, li, lw);
      chk($sformatf("beats_%0d", i), 32'(b), 32'(tbl[i].beats));
      if (tbl[i].last_in >= 0) begin
        chk($sformatf("last_in_%0d", i), 32'(li), 32'(tbl[i].last_in));
        chk($sformatf("last_w_%0d", i), 32'(lw), 32'(tbl[i].last_w));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
